ogpu_pio_in_bank: RTL and testbench

OGPU_PIO_IN_BANK -- requirements
Module: ogpu_pio_in_bank

---
 rtl/ogpu_pio_in_bank.sv | 160 ++++++++++++++++
 tb/tb_ogpu_pio_in_bank.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ogpu_pio_in_bank.sv
// ---------------------------------------------------------------------------
// ogpu_pio_in_bank
//   Bank of NUM_CH parallel input ports behind an Avalon-MM slave. Each input
//   bit is brought into the clk domain through a SYNC_STAGES flop chain, its
//   edges (rising / falling / any, chosen by EDGE_MODE) are latched into a
//   sticky capture register, and masked captures drive a level interrupt.
//
//   Register map per channel c (address = {c, r}):
//     r=0 DATA      RO   synchronized input value
//     r=1 EDGE_CAP  W1C  sticky edge capture (a new edge beats a clear)
//     r=2 IRQ_MASK  RW   per-bit interrupt enable
//     r=3 PENDING   RO   bit c = |(cap[c] & mask[c]); same value at every slot
//   Channels at or above NUM_CH read as 0 and ignore writes.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   chipselect  slave select, qualifies write
//   write       write strobe
//   address     {channel, register}
//   writedata   write data
//   in_port     asynchronous inputs, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   readdata    registered read data, one cycle after address
//   irq         registered OR of all PENDING bits
// ---------------------------------------------------------------------------
module ogpu_pio_in_bank #(
  parameter int  DATA_WIDTH  = 32,
  parameter int  NUM_CH      = 4,
  parameter int  SYNC_STAGES = 2,
  parameter int  EDGE_MODE   = 0,
  localparam int ADDR_W      = (($clog2(NUM_CH) + 2) < 2) ? 2 : ($clog2(NUM_CH) + 2)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         chipselect,
  input  logic                         write,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_WIDTH-1:0]        writedata,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0]        readdata,
  output logic                         irq
);

  localparam int BUS_W    = NUM_CH * DATA_WIDTH;
  localparam int CH_IDX_W = (ADDR_W > 2) ? (ADDR_W - 2) : 1;
  localparam logic [CH_IDX_W:0] NUM_CH_L = (CH_IDX_W + 1)'(NUM_CH);

  logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_pipe_r;
  logic [BUS_W-1:0]                  sync_s;
  logic [BUS_W-1:0]                  prev_r;
  logic [BUS_W-1:0]                  edge_s;
  logic [DATA_WIDTH-1:0]             sync_ch_s [NUM_CH];
  logic [DATA_WIDTH-1:0]             edge_ch_s [NUM_CH];
  logic [DATA_WIDTH-1:0]             cap_r     [NUM_CH];
  logic [DATA_WIDTH-1:0]             mask_r    [NUM_CH];
  logic [NUM_CH-1:0]                 pending_s;
  logic [CH_IDX_W-1:0]               ch_s;
  logic [1:0]                        reg_s;
  logic                              ch_valid_s;
  logic                              wr_en_s;
  logic [DATA_WIDTH-1:0]             rd_s;

  // With a single channel there are no channel bits in the address.
  if (ADDR_W > 2) begin : g_ch_idx
    assign ch_s = address[ADDR_W-1:2];
  end else begin : g_ch_idx_single
    assign ch_s = 1'b0;
  end

  assign reg_s      = address[1:0];
  assign ch_valid_s = ({1'b0, ch_s} < NUM_CH_L);
  assign wr_en_s    = chipselect & write & ch_valid_s;
  assign sync_s     = sync_pipe_r[SYNC_STAGES-1];

  // Synchronizer chain: index 0 samples the pins, the top index is sync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_pipe_r <= '0;
    end else begin
      sync_pipe_r <= {sync_pipe_r[SYNC_STAGES-2:0], in_port};
    end
  end

  // Previous synchronized value, the reference for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= '0;
    end else begin
      prev_r <= sync_s;
    end
  end

  // Edge vector selected by the build-time edge mode.
  always_comb begin
    case (EDGE_MODE)
      32'd0:   edge_s = sync_s & ~prev_r;
      32'd1:   edge_s = ~sync_s & prev_r;
      32'd2:   edge_s = sync_s ^ prev_r;
      default: edge_s = sync_s & ~prev_r;
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sync_ch_s[c] = sync_s[c*DATA_WIDTH +: DATA_WIDTH];
    assign edge_ch_s[c] = edge_s[c*DATA_WIDTH +: DATA_WIDTH];
    assign pending_s[c] = |(cap_r[c] & mask_r[c]);
  end

  // Capture and mask registers; the edge OR is applied after the W1C so a
  // simultaneous edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cap_r[c]  <= '0;
        mask_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_en_s && (reg_s == 2'd1) && (ch_s == CH_IDX_W'(c))) begin
          cap_r[c] <= (cap_r[c] & ~writedata) | edge_ch_s[c];
        end else begin
          cap_r[c] <= cap_r[c] | edge_ch_s[c];
        end
        if (wr_en_s && (reg_s == 2'd2) && (ch_s == CH_IDX_W'(c))) begin
          mask_r[c] <= writedata;
        end else begin
          mask_r[c] <= mask_r[c];
        end
      end
    end
  end

  // Read mux from the current address; no chipselect qualification.
  always_comb begin
    rd_s = '0;
    if (ch_valid_s) begin
      case (reg_s)
        2'd0:    rd_s = sync_ch_s[ch_s];
        2'd1:    rd_s = cap_r[ch_s];
        2'd2:    rd_s = mask_r[ch_s];
        2'd3:    rd_s[NUM_CH-1:0] = pending_s;
        default: rd_s = '0;
      endcase
    end else begin
      rd_s = '0;
    end
  end

  // Registered bus and interrupt outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_s;
      irq      <= |pending_s;
    end
  end

endmodule

// File: tb/tb_ogpu_pio_in_bank.sv
// ---------------------------------------------------------------------------
// tb_ogpu_pio_in_bank
//   dut_a: default build (32-bit, 4 channels, 2 sync stages, rising edges),
//          checked every cycle against a history-based reference model,
//          plus directed scenarios with literal expectations.
//   dut_b: single channel, any-edge capture.
//   dut_c: 8-bit, 3 channels, 3 sync stages, falling edges; exercises an
//          out-of-range channel and the deeper synchronizer latency.
// ---------------------------------------------------------------------------
module tb_ogpu_pio_in_bank;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // ---------------- dut_a ----------------
  logic         a_cs, a_wr, a_irq;
  logic [3:0]   a_addr;
  logic [31:0]  a_wd, a_rd;
  logic [127:0] a_in;

  ogpu_pio_in_bank dut_a (
    .clk(clk), .reset_n(reset_n), .chipselect(a_cs), .write(a_wr),
    .address(a_addr), .writedata(a_wd), .in_port(a_in),
    .readdata(a_rd), .irq(a_irq)
  );

  // ---------------- dut_b ----------------
  logic        b_cs, b_wr, b_irq;
  logic [1:0]  b_addr;
  logic [31:0] b_wd, b_in, b_rd;

  ogpu_pio_in_bank #(.NUM_CH(1), .EDGE_MODE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .chipselect(b_cs), .write(b_wr),
    .address(b_addr), .writedata(b_wd), .in_port(b_in),
    .readdata(b_rd), .irq(b_irq)
  );

  // ---------------- dut_c ----------------
  logic        c_cs, c_wr, c_irq;
  logic [3:0]  c_addr;
  logic [7:0]  c_wd, c_rd;
  logic [23:0] c_in;

  ogpu_pio_in_bank #(.DATA_WIDTH(8), .NUM_CH(3), .SYNC_STAGES(3), .EDGE_MODE(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .chipselect(c_cs), .write(c_wr),
    .address(c_addr), .writedata(c_wd), .in_port(c_in),
    .readdata(c_rd), .irq(c_irq)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model for dut_a ----------------
  // m_hist[i] is the pin value sampled i clock edges ago (0 = this edge).
  // The synchronized value seen at an edge is the pins SA edges earlier,
  // and the previous value is one edge older still.
  localparam int SA = 2;
  logic [127:0] m_hist [0:SA+1];
  logic [31:0]  m_cap  [4];
  logic [31:0]  m_mask [4];
  logic [31:0]  m_rd;
  logic         m_irq;

  task automatic model_reset();
    for (int i = 0; i <= SA + 1; i++) m_hist[i] = '0;
    for (int i = 0; i < 4; i++) begin
      m_cap[i]  = 32'd0;
      m_mask[i] = 32'd0;
    end
    m_rd  = 32'd0;
    m_irq = 1'b0;
  endtask

  task automatic model_edge(input logic cs, input logic wr, input logic [3:0] ad,
                            input logic [31:0] wd, input logic [127:0] pins);
    logic [127:0] now_v, was_v;
    logic [3:0]   pend;
    int           ch, r;
    for (int i = SA + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = pins;
    now_v = m_hist[SA];
    was_v = m_hist[SA+1];
    ch = int'(ad[3:2]);
    r  = int'(ad[1:0]);
    for (int i = 0; i < 4; i++) pend[i] = ((m_cap[i] & m_mask[i]) != 32'd0);
    case (r)
      0:       m_rd = now_v[ch*32 +: 32];
      1:       m_rd = m_cap[ch];
      2:       m_rd = m_mask[ch];
      default: m_rd = {28'd0, pend};
    endcase
    m_irq = (pend != 4'd0);
    if (cs && wr && r == 1) m_cap[ch] = m_cap[ch] & ~wd;
    if (cs && wr && r == 2) m_mask[ch] = wd;
    for (int i = 0; i < 4; i++)
      m_cap[i] = m_cap[i] | (now_v[i*32 +: 32] & ~was_v[i*32 +: 32]);
  endtask

  task automatic a_step(input logic cs, input logic wr, input logic [3:0] ad, input logic [31:0] wd);
    a_cs = cs; a_wr = wr; a_addr = ad; a_wd = wd;
    @(posedge clk);
    model_edge(cs, wr, ad, wd, a_in);
    @(negedge clk);
    check_val("a_readdata", a_rd, m_rd);
    check_val("a_irq", {31'd0, a_irq}, {31'd0, m_irq});
  endtask

  task automatic b_step(input logic wr, input logic [1:0] ad, input logic [31:0] wd);
    b_cs = wr; b_wr = wr; b_addr = ad; b_wd = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic c_step(input logic cs, input logic wr, input logic [3:0] ad, input logic [7:0] wd);
    c_cs = cs; c_wr = wr; c_addr = ad; c_wd = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    a_cs = 1'b0; a_wr = 1'b0; a_addr = 4'd0; a_wd = 32'd0; a_in = '0;
    b_cs = 1'b0; b_wr = 1'b0; b_addr = 2'd0; b_wd = 32'd0; b_in = 32'd0;
    c_cs = 1'b0; c_wr = 1'b0; c_addr = 4'd0; c_wd = 8'd0;  c_in = 24'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_readdata", a_rd, 32'd0);
    check_val("reset_irq", {31'd0, a_irq}, 32'd0);
    reset_n = 1'b1;

    // Synchronizer latency on channel 1 data.
    a_in[63:32] = 32'h0000_00A5;
    a_step(1'b0, 1'b0, 4'b0100, 32'd0);
    a_step(1'b0, 1'b0, 4'b0100, 32'd0);
    check_val("data_ch1_early", a_rd, 32'd0);
    a_step(1'b0, 1'b0, 4'b0100, 32'd0);
    check_val("data_ch1", a_rd, 32'h0000_00A5);
    a_step(1'b0, 1'b0, 4'b0000, 32'd0);
    check_val("data_ch0", a_rd, 32'd0);

    // Rising edge on ch2 bit3 with its mask enabled.
    a_in[67] = 1'b1;
    a_step(1'b1, 1'b1, 4'b1010, 32'h8);
    a_step(1'b0, 1'b0, 4'b1001, 32'd0);
    a_step(1'b0, 1'b0, 4'b1001, 32'd0);
    check_val("irq_before_cap", {31'd0, a_irq}, 32'd0);
    a_step(1'b0, 1'b0, 4'b1001, 32'd0);
    check_val("cap_ch2", a_rd, 32'h8);
    check_val("irq_ch2", {31'd0, a_irq}, 32'd1);
    a_step(1'b0, 1'b0, 4'b0011, 32'd0);
    check_val("pending_ch2", a_rd, 32'h4);
    a_step(1'b1, 1'b1, 4'b1001, 32'h8);
    check_val("irq_at_clear", {31'd0, a_irq}, 32'd1);
    a_step(1'b0, 1'b0, 4'b1001, 32'd0);
    check_val("irq_after_clear", {31'd0, a_irq}, 32'd0);

    // Edge arriving on the same edge as a W1C of that bit.
    a_in[0] = 1'b1;
    a_step(1'b0, 1'b0, 4'b0001, 32'd0);
    a_step(1'b0, 1'b0, 4'b0001, 32'd0);
    a_step(1'b1, 1'b1, 4'b0001, 32'h1);
    a_step(1'b0, 1'b0, 4'b0001, 32'd0);
    check_val("set_beats_clear", a_rd, 32'h1);

    // Masked capture on ch3 bit31, then unmask.
    a_in[127] = 1'b1;
    repeat (4) a_step(1'b0, 1'b0, 4'b1101, 32'd0);
    check_val("cap_ch3_masked", a_rd, 32'h8000_0000);
    check_val("irq_masked", {31'd0, a_irq}, 32'd0);
    a_step(1'b1, 1'b1, 4'b1110, 32'h8000_0000);
    a_step(1'b0, 1'b0, 4'b1110, 32'd0);
    check_val("irq_unmasked", {31'd0, a_irq}, 32'd1);

    // Short reset pulse between clock edges.
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_pulse_readdata", a_rd, 32'd0);
    check_val("rst_pulse_irq", {31'd0, a_irq}, 32'd0);
    reset_n = 1'b1;
    a_step(1'b0, 1'b0, 4'b1101, 32'd0);
    check_val("rst_cap_ch3", a_rd, 32'd0);
    a_step(1'b0, 1'b0, 4'b1110, 32'd0);
    check_val("rst_mask_ch3", a_rd, 32'd0);
    a_step(1'b0, 1'b0, 4'b0011, 32'd0);
    check_val("rst_pending", a_rd, 32'd0);
    a_step(1'b0, 1'b0, 4'b1101, 32'd0);
    check_val("rise_after_reset", a_rd, 32'h8000_0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) a_in[$urandom_range(127)] ^= 1'b1;
      if ($urandom_range(31) == 0) a_in = {$urandom, $urandom, $urandom, $urandom};
      a_step(1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)),
             ($urandom_range(1) == 0) ? $urandom : (32'd1 << $urandom_range(31)));
    end

    // dut_b: any-edge capture on a single channel.
    b_in = 32'd1;
    repeat (4) b_step(1'b0, 2'd1, 32'd0);
    check_val("b_cap_rise", b_rd, 32'd1);
    b_step(1'b1, 2'd1, 32'd1);
    b_step(1'b0, 2'd1, 32'd0);
    check_val("b_w1c", b_rd, 32'd0);
    b_in = 32'd0;
    repeat (4) b_step(1'b0, 2'd1, 32'd0);
    check_val("b_cap_fall", b_rd, 32'd1);
    b_step(1'b1, 2'd1, 32'd1);
    b_step(1'b0, 2'd1, 32'd0);
    check_val("b_w1c_2", b_rd, 32'd0);
    b_in = 32'd1;
    repeat (4) b_step(1'b0, 2'd1, 32'd0);
    check_val("b_cap_rise2", b_rd, 32'd1);
    b_step(1'b1, 2'd3, 32'hFFFF_FFFF);
    b_step(1'b1, 2'd0, 32'hFFFF_FFFF);
    b_step(1'b0, 2'd1, 32'd0);
    check_val("b_ro_write_cap", b_rd, 32'd1);
    b_step(1'b0, 2'd2, 32'd0);
    check_val("b_ro_write_mask", b_rd, 32'd0);
    check_val("b_irq_idle", {31'd0, b_irq}, 32'd0);
    b_step(1'b0, 2'd0, 32'd0);
    check_val("b_data", b_rd, 32'd1);
    b_step(1'b1, 2'd2, 32'd1);
    b_step(1'b0, 2'd3, 32'd0);
    check_val("b_pending", b_rd, 32'd1);
    check_val("b_irq", {31'd0, b_irq}, 32'd1);

    // dut_c: falling edges, out-of-range channel 3, chipselect gating.
    c_in[15:8] = 8'hFF;
    repeat (6) c_step(1'b0, 1'b0, 4'b0101, 8'd0);
    check_val("c_no_rise", {24'd0, c_rd}, 32'd0);
    c_in[15:8] = 8'h0F;
    repeat (6) c_step(1'b0, 1'b0, 4'b0101, 8'd0);
    check_val("c_fall", {24'd0, c_rd}, 32'hF0);
    c_step(1'b1, 1'b1, 4'b1101, 8'hFF);
    c_step(1'b1, 1'b1, 4'b1110, 8'hFF);
    c_step(1'b0, 1'b0, 4'b0101, 8'd0);
    check_val("c_oor_w1c", {24'd0, c_rd}, 32'hF0);
    c_step(1'b0, 1'b0, 4'b1110, 8'd0);
    check_val("c_oor_read_mask", {24'd0, c_rd}, 32'd0);
    c_step(1'b0, 1'b0, 4'b1100, 8'd0);
    check_val("c_oor_read_data", {24'd0, c_rd}, 32'd0);
    check_val("c_irq_idle", {31'd0, c_irq}, 32'd0);
    c_step(1'b0, 1'b1, 4'b0110, 8'h10);
    c_step(1'b0, 1'b0, 4'b0110, 8'd0);
    check_val("c_cs_gate", {24'd0, c_rd}, 32'd0);
    c_step(1'b1, 1'b1, 4'b0110, 8'h10);
    c_step(1'b0, 1'b0, 4'b0011, 8'd0);
    check_val("c_pending", {24'd0, c_rd}, 32'h2);
    check_val("c_irq", {31'd0, c_irq}, 32'd1);
    c_in[7:0] = 8'h3C;
    repeat (3) c_step(1'b0, 1'b0, 4'b0000, 8'd0);
    check_val("c_sync_early", {24'd0, c_rd}, 32'd0);
    c_step(1'b0, 1'b0, 4'b0000, 8'd0);
    check_val("c_sync_latency", {24'd0, c_rd}, 32'h3C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
